run_ctrl: RTL

- Synthesizable run controller for the single-cycle RISC-V core.
- Replaces the hard-coded reset pulse and fixed end time of the simulation flow with a parametrised sequencer.
- Sequencer drives core reset for a configurable hold, counts run cycles, and watches data-memory writes to a TOHOST address to decide pass/fail.
- Sequencer enforces a cycle-budget timeout. Sits beside `top`, snooping the DM write port.

---
 rtl/run_ctrl_pkg.sv | 9 +
 rtl/run_ctrl_hang_det.sv | 27 ++
 rtl/run_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared FSM state codes, TOHOST pass value and run end-cause enum for run_ctrl.
package run_ctrl_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RESET = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam int TOHOST_PASS = 1;
   typedef enum logic [2:0] {EC_NONE, EC_PASS, EC_FAIL, EC_TIMEOUT, EC_HANG} end_cause_t;
endpackage

// File: rtl/run_ctrl_hang_det.sv
// run_ctrl_hang_det: counts consecutive RUN cycles with an unchanged pc; flags the cycle the count reaches HANG_CYCLES.
module run_ctrl_hang_det #(
   parameter int ADDR_W = 32,
   parameter int HANG_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [ADDR_W-1:0] pc,
   output logic              stall
);
   localparam int CW = $clog2(HANG_CYCLES + 1);
   logic [ADDR_W-1:0] prev;
   logic [CW-1:0] cnt;
   logic same;
   assign same = pc == prev;
   assign stall = en && same && cnt == CW'(HANG_CYCLES - 1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev <= '0;
         cnt <= '0;
      end else begin
         prev <= pc;
         cnt <= en && same ? cnt + 1'b1 : '0;
      end
   end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: reset/run sequencer for the RISC-V core, ending runs on a TOHOST write or cycle-budget timeout.
// Define RUN_CTRL_HANG_EN to add the pc-stall hang detector (pc input, hang output, HANG_CYCLES parameter).
module run_ctrl import run_ctrl_pkg::*; #(
`ifdef RUN_CTRL_HANG_EN
   parameter int HANG_CYCLES = 8,
`endif
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0000_0FF0,
   parameter int RST_HOLD = 2,
   parameter int MAX_CYCLES = 100
) (
`ifdef RUN_CTRL_HANG_EN
   input  logic [ADDR_W-1:0] pc,
   output logic              hang,
`endif
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              core_rst,
   output logic              running,
   output logic              done,
   output logic              pass,
   output logic [DATA_W-1:0] fail_code,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_cnt
);
   localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
   logic [1:0] state;
   logic [HW-1:0] hold;
   logic hit, stall;
   end_cause_t cause;
`ifdef RUN_CTRL_HANG_EN
   run_ctrl_hang_det #(.ADDR_W(ADDR_W), .HANG_CYCLES(HANG_CYCLES)) u_hang (
      .clk(clk), .rst(rst), .en(state == RUN), .pc(pc), .stall(stall)
   );
`else
   assign stall = 1'b0;
`endif
   // Priority: TOHOST hit, then hang, then budget expiry.
   always_comb begin
      hit = dm_we && dm_addr == TOHOST_ADDR && dm_wdata != '0;
      cause = state != RUN ? EC_NONE :
              hit ? (dm_wdata == DATA_W'(TOHOST_PASS) ? EC_PASS : EC_FAIL) :
              stall ? EC_HANG :
              cycle_cnt == CNT_W'(MAX_CYCLES - 1) ? EC_TIMEOUT : EC_NONE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         hold <= '0;
         core_rst <= 1'b1;
         running <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         fail_code <= '0;
         timeout <= 1'b0;
         cycle_cnt <= '0;
`ifdef RUN_CTRL_HANG_EN
         hang <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= RESET;
               hold <= '0;
            end
            RESET: if (hold == HW'(RST_HOLD - 1)) begin
               state <= RUN;
               core_rst <= 1'b0;
               running <= 1'b1;
               cycle_cnt <= '0;
            end else hold <= hold + 1'b1;
            RUN: if (cause != EC_NONE) begin
               state <= DONE;
               core_rst <= 1'b1;
               running <= 1'b0;
               done <= 1'b1;
               pass <= cause == EC_PASS;
               fail_code <= cause == EC_FAIL ? dm_wdata >> 1 : '0;
               timeout <= cause == EC_TIMEOUT;
`ifdef RUN_CTRL_HANG_EN
               hang <= cause == EC_HANG;
`endif
            end else cycle_cnt <= cycle_cnt + 1'b1;
            DONE: if (start) begin
               state <= RESET;
               hold <= '0;
               done <= 1'b0;
               pass <= 1'b0;
               fail_code <= '0;
               timeout <= 1'b0;
`ifdef RUN_CTRL_HANG_EN
               hang <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
